muldiv_unit: RTL and testbench

//  Iterative multi-cycle multiply/divide unit that serves MULT/MULTU/DIV/DIVU requests from the CPU control path.
//  The control path is the initiator and this block is the responder.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit - iterative N-cycle MULT/MULTU/DIV/DIVU unit producing a registered HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes; signs are re-applied in the FIN cycle.
module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [1:0]      op_q, op_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [N-1:0]    opb_q, opb_d;
   logic [N-1:0]    araw_q, araw_d;
   logic            neg_res_q, neg_res_d;
   logic            neg_rem_q, neg_rem_d;
   logic            zdiv_q, zdiv_d;
   logic [N-1:0]    hi_q, hi_d;
   logic [N-1:0]    lo_q, lo_d;
   logic            done_q, done_d;
   logic            dbz_q, dbz_d;

   logic            is_signed, accept, b_zero;
   logic [N-1:0]    abs_a, abs_b;
   logic [N:0]      mul_sum;
   logic [2*N:0]    div_shift;
   logic [N:0]      div_trial;
   logic [2*N-1:0]  mul_next, div_next, prod;
   logic [N-1:0]    quo, rem;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      araw_d    = araw_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      zdiv_d    = zdiv_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;

      is_signed = ~op[0];
      abs_a     = (is_signed && a[N-1]) ? -a : a;
      abs_b     = (is_signed && b[N-1]) ? -b : b;
      b_zero    = (b == '0);
      accept    = start && (state_q != RUN);

      // Multiply: accumulator upper half gathers partial sums, lower half shifts out multiplier bits.
      mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[N-1:1]};
      // Divide: {remainder, quotient} shifts left; quotient bit lands in the vacated LSB.
      div_shift = {acc_q, 1'b0};
      div_trial = div_shift[2*N:N] - {1'b0, opb_q};
      div_next  = div_trial[N] ? div_shift[2*N-1:0]
                               : {div_trial[N-1:0], div_shift[N-1:1], 1'b1};

      prod = neg_res_q ? -acc_q : acc_q;
      quo  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
      rem  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

      case (state_q)
         RUN: begin
            count_d = count_q + 1'b1;
            acc_d   = op_q[1] ? div_next : mul_next;
            if (count_q == CW'(N - 1)) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (zdiv_q) begin
               hi_d  = araw_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d  = op_q[1] ? rem : prod[2*N-1:N];
               lo_d  = op_q[1] ? quo : prod[N-1:0];
               dbz_d = 1'b0;
            end
         end
         default: ;
      endcase

      if (accept) begin
         op_d      = op;
         araw_d    = a;
         acc_d     = {{N{1'b0}}, op[1] ? abs_a : abs_b};
         opb_d     = op[1] ? abs_b : abs_a;
         neg_res_d = is_signed && (a[N-1] ^ b[N-1]);
         neg_rem_d = is_signed && a[N-1];
         zdiv_d    = op[1] && b_zero;
         count_d   = '0;
         state_d   = (op[1] && b_zero) ? FIN : RUN;
         // A start coinciding with FIN leaves the flag to the op that is completing.
         if (state_q != FIN) dbz_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         op_q      <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         araw_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zdiv_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         araw_q    <= araw_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         zdiv_q    <= zdiv_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors and random ops vs an arithmetic model.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   muldiv_unit #(.N(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   logic [31:0] last_hi  = '0;
   logic [31:0] last_lo  = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference result from plain integer arithmetic: {dbz, hi, lo}.
   function automatic logic [64:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
      longint      sa, sb2, p, q, r;
      logic [63:0] u, uq, ur;
      logic [31:0] h, l;
      logic        z;
      sa  = longint'($signed(ma));
      sb2 = longint'($signed(mb));
      z   = 1'b0;
      case (mop)
         2'b00: begin p = sa * sb2; u = p; h = u[63:32]; l = u[31:0]; end
         2'b01: begin u = {32'b0, ma} * {32'b0, mb}; h = u[63:32]; l = u[31:0]; end
         default: begin
            if (mb == 0) begin
               z = 1'b1; h = ma; l = 32'hFFFF_FFFF;
            end else if (mop == 2'b10) begin
               q = sa / sb2; r = sa % sb2; uq = q; ur = r;
               h = ur[31:0]; l = uq[31:0];
            end else begin
               uq = {32'b0, ma} / {32'b0, mb}; ur = {32'b0, ma} % {32'b0, mb};
               h = ur[31:0]; l = uq[31:0];
            end
         end
      endcase
      return {z, h, l};
   endfunction

   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            last_hi = e.hi;
            last_lo = e.lo;
         end
      end
   end

   task automatic issue_exp(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
      exp_t e;
      int   t;
      t = 0;
      while (busy && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("wait_not_busy", 64'(busy), 64'(0));
      start = 1'b1; op = iop; a = ia; b = ib;
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      e.cyc = cyc + 1 + ((edbz) ? 1 : 33);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib);
      logic [64:0] m;
      m = model(iop, ia, ib);
      issue_exp(iop, ia, ib, m[63:32], m[31:0], m[64]);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
      chk("drain_timeout", 64'(sb.size()), 64'(0));
      repeat (3) @(negedge clk);
      chk("hold_hi", 64'(hi), 64'(last_hi));
      chk("hold_lo", 64'(lo), 64'(last_lo));
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h0000_0000;
         1: v = 32'h0000_0001;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int cnt;
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_dbz", 64'(div_by_zero), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      issue_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      drain();
      issue_exp(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      cnt = 0;
      while (busy && cnt < 100) begin cnt++; @(negedge clk); end
      chk("busy_cycles", 64'(cnt), 64'(32));
      drain();
      issue_exp(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      issue_exp(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      issue_exp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      drain();
      issue_exp(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      drain();
      issue_exp(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      chk("dbz_cleared", 64'(div_by_zero), 64'(0));
      drain();

      // Starts while busy must be dropped without disturbing the in-flight result.
      issue_exp(2'b01, 32'd12345, 32'd678, 32'd0, 32'd8369910, 1'b0);
      start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd0;
      repeat (5) @(negedge clk);
      start = 1'b0;
      drain();

      // Back-to-back: each start lands in the previous FIN cycle.
      issue(2'b00, 32'h1234_5678, 32'h8765_4321);
      issue(2'b10, 32'h8000_0000, 32'd3);
      issue(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      drain();

      issue(2'b01, 32'hAAAA_AAAA, 32'h5555_5555);
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrun_busy", 64'(busy), 64'(0));
      chk("midrun_hi", 64'(hi), 64'(0));
      chk("midrun_lo", 64'(lo), 64'(0));
      chk("midrun_done", 64'(done), 64'(0));
      sb.delete();
      last_hi = '0; last_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      issue(2'b10, 32'hFFFF_FF9C, 32'd7);
      drain();

      for (int i = 0; i < 1500; i++) begin
         issue(2'($urandom), pick(), pick());
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
